// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the FFT output reorder buffer.
//   MODE_*        : read-order selection codes carried on the 2-bit mode port
//   bank_state_t  : life cycle of one ping-pong bank
//   norm_mode()   : folds the unused code 3 onto natural order
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam logic [1:0] MODE_NAT    = 2'd0;
    localparam logic [1:0] MODE_BITREV = 2'd1;
    localparam logic [1:0] MODE_SHIFT  = 2'd2;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2,
        BANK_DRAIN = 2'd3
    } bank_state_t;

    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return ((m == MODE_BITREV) || (m == MODE_SHIFT)) ? m : MODE_NAT;
    endfunction

endpackage

// File: rtl/fft_reorder_bitrev_addr.sv
// ---------------------------------------------------------------------------
// bitrev_addr
// Combinational read-address generator for the reorder buffer.
//   k    : output sample index within the frame
//   mode : MODE_NAT -> k, MODE_BITREV -> bitrev(k),
//          MODE_SHIFT -> bitrev(k ^ NPT/2)   (any other code -> k)
//   addr : bank word address to read
// ---------------------------------------------------------------------------
module bitrev_addr
    import fft_pkg::*;
#(
    parameter int LOG2N = 3
) (
    input  logic [LOG2N-1:0] k,
    input  logic [1:0]       mode,
    output logic [LOG2N-1:0] addr
);

    logic [LOG2N-1:0] k_sel;
    logic [LOG2N-1:0] k_rev;

    // fftshift of the natural-order index is a flip of its MSB, applied
    // before the reversal so the shifted spectrum comes out bit-reversed.
    always_comb begin
        k_sel = k;
        if (mode == MODE_SHIFT) begin
            k_sel = k ^ {1'b1, {(LOG2N-1){1'b0}}};
        end
    end

    generate
        for (genvar gi = 0; gi < LOG2N; gi++) begin : g_rev
            assign k_rev[gi] = k_sel[LOG2N-1-gi];
        end
    endgenerate

    always_comb begin
        addr = k;
        if ((mode == MODE_BITREV) || (mode == MODE_SHIFT)) begin
            addr = k_rev;
        end
    end

endmodule

// File: rtl/fft_reorder.sv
// ---------------------------------------------------------------------------
// fft_reorder
// Ping-pong frame buffer that reorders FFT output samples.
// One bank fills in arrival order while the other drains in the order
// selected by the mode that was present on the frame's first sample.
//   clk, rst_n             : clock, asynchronous active-low reset
//   mode                   : read order (latched per frame at in_sof)
//   in_valid/in_ready      : input handshake; in_sof marks sample 0
//   in_re/in_im            : input sample
//   out_valid/out_ready    : output handshake; out_sof/out_eof frame marks
//   out_re/out_im          : output sample
//   err_short              : sticky, set when a frame restarts early
// ---------------------------------------------------------------------------
module fft_reorder
    import fft_pkg::*;
#(
    parameter int LOG2N = 3,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   mode,
    input  logic         in_valid,
    input  logic         in_sof,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_sof,
    output logic         out_eof,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         err_short
);

    localparam int NPT = 1 << LOG2N;
    localparam logic [LOG2N-1:0] ADDR_LAST = '1;

    // Both banks share one array; the bank pointer is the address MSB.
    logic [2*W-1:0]   mem_q [0:2*NPT-1];

    bank_state_t      bank_st_q   [2];
    bank_state_t      bank_st_d   [2];
    logic [1:0]       bank_mode_q [2];
    logic [1:0]       bank_mode_d [2];
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] wr_addr_q, wr_addr_d;
    logic [LOG2N-1:0] rd_k_q, rd_k_d;
    logic             out_valid_q, out_valid_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eof_q, out_eof_d;
    logic [W-1:0]     out_re_q, out_re_d;
    logic [W-1:0]     out_im_q, out_im_d;
    logic             err_short_q, err_short_d;

    logic             wr_en;
    logic [LOG2N-1:0] wr_a;
    logic [LOG2N-1:0] rd_addr;
    logic             accept;
    logic             load_en;
    logic             rd_avail;

    bitrev_addr #(.LOG2N(LOG2N)) u_bitrev (
        .k    (rd_k_q),
        .mode (bank_mode_q[rd_bank_q]),
        .addr (rd_addr)
    );

    assign in_ready = (bank_st_q[wr_bank_q] == BANK_EMPTY) ||
                      (bank_st_q[wr_bank_q] == BANK_FILL);
    assign accept   = in_valid && in_ready;
    assign load_en  = !out_valid_q || out_ready;
    assign rd_avail = (bank_st_q[rd_bank_q] == BANK_FULL) ||
                      (bank_st_q[rd_bank_q] == BANK_DRAIN);

    // Write and read sides only ever touch banks in disjoint states
    // (EMPTY/FILL vs FULL/DRAIN), so their updates never collide.
    always_comb begin
        bank_st_d   = bank_st_q;
        bank_mode_d = bank_mode_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_addr_d   = wr_addr_q;
        rd_k_d      = rd_k_q;
        out_valid_d = out_valid_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        err_short_d = err_short_q;
        wr_en       = 1'b0;
        wr_a        = wr_addr_q;

        // ---- write side ----
        if (accept) begin
            if (in_sof) begin
                // A new frame always (re)starts the current write bank.
                wr_en                  = 1'b1;
                wr_a                   = '0;
                wr_addr_d              = LOG2N'(1);
                bank_st_d[wr_bank_q]   = BANK_FILL;
                bank_mode_d[wr_bank_q] = norm_mode(mode);
                if (wr_addr_q != '0) begin
                    err_short_d = 1'b1;
                end
            end else if (bank_st_q[wr_bank_q] == BANK_FILL) begin
                wr_en = 1'b1;
                if (wr_addr_q == ADDR_LAST) begin
                    bank_st_d[wr_bank_q] = BANK_FULL;
                    wr_bank_d            = ~wr_bank_q;
                    wr_addr_d            = '0;
                end else begin
                    wr_addr_d = wr_addr_q + 1'b1;
                end
            end
            // otherwise: stray sample outside a frame, silently dropped
        end

        // ---- read side ----
        if (load_en) begin
            if (rd_avail) begin
                out_valid_d          = 1'b1;
                out_sof_d            = (rd_k_q == '0);
                out_eof_d            = (rd_k_q == ADDR_LAST);
                {out_re_d, out_im_d} = mem_q[{rd_bank_q, rd_addr}];
                if (rd_k_q == ADDR_LAST) begin
                    bank_st_d[rd_bank_q] = BANK_EMPTY;
                    rd_bank_d            = ~rd_bank_q;
                    rd_k_d               = '0;
                end else begin
                    bank_st_d[rd_bank_q] = BANK_DRAIN;
                    rd_k_d               = rd_k_q + 1'b1;
                end
            end else begin
                out_valid_d = 1'b0;
                out_sof_d   = 1'b0;
                out_eof_d   = 1'b0;
            end
        end
    end

    // Sample storage carries no reset; stale contents are never read
    // because a bank is only drained after being completely refilled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_bank_q, wr_a}] <= {in_re, in_im};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_st_q[0]   <= BANK_EMPTY;
            bank_st_q[1]   <= BANK_EMPTY;
            bank_mode_q[0] <= MODE_NAT;
            bank_mode_q[1] <= MODE_NAT;
            wr_bank_q      <= 1'b0;
            rd_bank_q      <= 1'b0;
            wr_addr_q      <= '0;
            rd_k_q         <= '0;
            out_valid_q    <= 1'b0;
            out_sof_q      <= 1'b0;
            out_eof_q      <= 1'b0;
            out_re_q       <= '0;
            out_im_q       <= '0;
            err_short_q    <= 1'b0;
        end else begin
            bank_st_q      <= bank_st_d;
            bank_mode_q    <= bank_mode_d;
            wr_bank_q      <= wr_bank_d;
            rd_bank_q      <= rd_bank_d;
            wr_addr_q      <= wr_addr_d;
            rd_k_q         <= rd_k_d;
            out_valid_q    <= out_valid_d;
            out_sof_q      <= out_sof_d;
            out_eof_q      <= out_eof_d;
            out_re_q       <= out_re_d;
            out_im_q       <= out_im_d;
            err_short_q    <= err_short_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign err_short = err_short_q;

endmodule

// File: doc/fft_reorder.md
FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 SHALL have parameter LOG2N, default 3, meaning log2 of frame length NPT = 1<<LOG2N (LOG2N 2..10).
REQ-002 SHALL have parameter W, default 16, meaning signed width of each real/imag component.
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 mode  in  2  0 natural, 1 bit-reverse, 2 bit-reverse+fftshift, 3 treated as 0.
REQ-006 in_valid  in  1  input sample valid.
REQ-007 in_sof  in  1  first sample of frame, qualified by in_valid.
REQ-008 in_re, in_im  in  W each  input sample, signed.
REQ-009 in_ready  out  1  sample accepted when in_valid&&in_ready.
REQ-010 out_valid  out  1  output sample valid.
REQ-011 out_ready  in  1  downstream accept.
REQ-012 out_sof, out_eof  out  1 each  first/last sample of output frame.
REQ-013 out_re, out_im  out  W each  output sample.
REQ-014 err_short  out  1  sticky: frame aborted by early in_sof.

Function
REQ-015 SHALL hold two banks (ping-pong), each NPT x 2W, each with state EMPTY, FILL, FULL or DRAIN.
REQ-016 Write side: accepted sample with in_sof selects current write bank, write addr 0, bank -> FILL, mode latched for that bank.
REQ-017 Accepted samples before any in_sof, or while write bank not FILL, SHALL be dropped (in_ready still 1 if bank EMPTY).
REQ-018 Write addr SHALL increment per accepted sample; write at NPT-1 makes bank FULL and toggles write bank.
REQ-019 in_sof accepted when write addr != 0 SHALL set err_short, restart the same bank at addr 0 with the new sample.
REQ-020 in_ready SHALL be 1 iff current write bank is EMPTY or FILL.
REQ-021 Read side: when read bank FULL, bank -> DRAIN, read count k from 0 to NPT-1.
REQ-022 Read addr: mode 0 k; mode 1 bitrev(k); mode 2 bitrev(k XOR NPT/2); bitrev over LOG2N bits.
REQ-023 Output registers SHALL load when !out_valid || out_ready; otherwise hold all outputs stable.
REQ-024 out_sof SHALL be 1 with k=0 sample; out_eof with k=NPT-1 sample.
REQ-025 After k=NPT-1 is loaded, bank -> EMPTY and read bank toggles at the same edge.
REQ-026 Latency: last input sample accepted at edge t -> first output sample valid after edge t+1.
REQ-027 With out_ready=1 and contiguous input, SHALL sustain one sample/cycle with no in_ready bubbles across frames.
REQ-028 Both banks FULL/DRAIN -> in_ready=0 until a bank becomes EMPTY; no sample lost or overwritten.
REQ-029 Mode change mid-frame SHALL not affect frames already latched.

Reset
REQ-030 rst_n low SHALL asynchronously force: banks EMPTY, both bank pointers 0, counters 0, out_valid/out_sof/out_eof 0, out_re/out_im 0, err_short 0, in_ready 1 after release.
REQ-031 Reset mid-frame SHALL discard all stored samples; bank memory contents need not be cleared.

Structure
REQ-032 Package fft_pkg SHALL hold mode constants (MODE_NAT, MODE_BITREV, MODE_SHIFT) and bank-state enum.
REQ-033 Sub-module bitrev_addr (param LOG2N, combinational) SHALL compute the read address from k and mode.
REQ-034 Bank memory SHALL be flop array or inferred RAM with registered read; no other sub-modules.

Verification (LOG2N=3, inputs re=j, im=-j for sample j)
REQ-035 Mode 1, one frame, out_ready=1 -> out_re 0,4,2,6,1,5,3,7; out_sof on first, out_eof on last; first valid 2 edges after last input.
REQ-036 Mode 2 -> out_re 1,5,3,7,0,4,2,6; mode 0 -> 0..7.
REQ-037 Four back-to-back frames, out_ready=1 -> in_ready stays 1, 32 outputs contiguous, correct per frame.
REQ-038 out_ready=0 held 20 cycles during frames -> in_ready drops after 16 samples stored, outputs stable, resume with no loss/duplicate.
REQ-039 in_sof at sample 5 -> err_short=1, restarted frame output complete and correct; err_short held until reset.
REQ-040 rst_n pulsed low mid-drain -> out_valid 0 immediately, next frame after release outputs correctly.
